mem_request_sequencer: RTL and testbench
========================================

Name: mem_request_sequencer

Overview:
- Sits directly downstream of the load/store queue dispatch port and upstream of the data cache.
- Accepts one committed load or store per handshake and holds it stable while the cache services it.
- On a miss it waits for the refill, then replays the access.
- Returns load data tagged with the active-list id, and reports store completion with the queue index.
- Drives the dc_miss stall used by the hazard unit to freeze queue read pointers.

Parameters:
- ADDR_W, 26, word-address width
- DATA_W, 32, data width
- LSQ_IDX_W, 3, load/store queue index width
- AL_IDX_W, 5, active-list id width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request from load/store queue
- req_ready  out  1  sequencer can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  access address
- req_data  in  DATA_W  store data
- req_index  in  LSQ_IDX_W  queue entry index
- req_alid  in  AL_IDX_W  active-list id
- flush  in  1  misprediction recovery, kills in-flight load
- dc_valid  out  1  cache access strobe
- dc_write  out  1  cache write enable
- dc_addr  out  ADDR_W  cache address
- dc_wdata  out  DATA_W  cache write data
- dc_hit  in  1  same-cycle hit for the current dc_valid access
- dc_rdata  in  DATA_W  read data, valid with dc_hit
- dc_refill_done  in  1  one-cycle pulse, refill complete
- dc_miss  out  1  stall to hazard unit
- ld_valid  out  1  load response pulse
- ld_data  out  DATA_W  load data
- ld_alid  out  AL_IDX_W  load active-list id
- st_done  out  1  store completion pulse
- st_index  out  LSQ_IDX_W  completed store queue index

Behaviour:
- Reset is asynchronous and active-low. Clock is clk, reset is rst_n, and there is one clock domain.
- Reset values:
  - State = IDLE; all held request registers = 0.
  - ld_valid, st_done, dc_valid, dc_miss = 0; all data/index outputs = 0.
  - req_ready = 1.
- FSM states: IDLE, LOOKUP, MISS_WAIT, RESPOND.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch write/addr/data/index/alid and go to LOOKUP.
  - If flush and !req_write are seen in the same cycle, the load is not accepted and the state stays IDLE.
- LOOKUP:
  - dc_valid = 1; dc_write/dc_addr/dc_wdata come from the held registers.
  - dc_hit = 1: capture dc_rdata and go to RESPOND.
  - dc_hit = 0: dc_miss = 1 and go to MISS_WAIT.
- MISS_WAIT:
  - dc_miss = 1 and dc_valid = 0.
  - On dc_refill_done, go to LOOKUP (replay). The replay must hit.
- RESPOND:
  - Store: st_done = 1 and st_index = held index, for exactly one cycle.
  - Load: ld_valid = 1 with ld_data and ld_alid, for exactly one cycle.
  - Next state is IDLE.
- Latency: accept at N, lookup at N+1, response at N+2 on a hit. On a miss, response comes 2 cycles after the dc_refill_done pulse.
- req_ready = 0 in every state except IDLE. Throughput is one request per 3 cycles on hits.
- flush:
  - Held load: the load is marked killed. It continues to MISS_WAIT or LOOKUP normally so that cache state stays consistent, but ld_valid is suppressed in RESPOND.
  - Held store: flush has no effect, because stores are committed.
  - A flush arriving in the same cycle as RESPOND suppresses that cycle's ld_valid.
- dc_refill_done outside MISS_WAIT is ignored.
- Outputs are glitch-free and registered except dc_valid and dc_miss, which are decoded from state.

Optional Feature:
- MEM_SEQ_PERF_CNT_EN.
- Enabled: adds 32-bit counters hit_cnt, miss_cnt and stall_cycles, exported as output ports perf_hit, perf_miss and perf_stall.
  - hit_cnt increments per LOOKUP hit; replays count as hits.
  - miss_cnt increments per LOOKUP miss.
  - stall_cycles increments each cycle dc_miss = 1.
  - All counters reset to 0 and saturate at all-ones.
- Disabled: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared core package holds:
  - the FSM state enum mem_seq_state_t;
  - the request struct mem_req_t (write, addr, data, index, alid, killed);
  - the MEM_ACTION READ/WRITE encoding already used by the cache interface.
- One natural sub-module: mem_seq_perf_counters, instantiated only under MEM_SEQ_PERF_CNT_EN.

Test Plan:
1. Load hit: req load addr 0x40, alid 5, dc_hit = 1 with rdata 0xDEADBEEF at N+1 -> ld_valid at N+2 with data 0xDEADBEEF, alid 5; req_ready low for N+1..N+2.
2. Store miss: req store addr 0x80, data 0x1234, index 3; dc_hit = 0 at N+1; dc_refill_done at N+6; hit at N+7 -> dc_miss high N+1..N+6, st_done with st_index 3 at N+8, and exactly two dc_valid strobes.
3. Flush during load miss: load alid 7 misses, flush in MISS_WAIT, refill completes -> no ld_valid pulse; FSM returns to IDLE and req_ready = 1.
4. Flush on a held store: store index 2, flush in LOOKUP -> st_done still pulses with index 2.
5. Async reset mid-MISS_WAIT: rst_n low for 1 ns -> dc_miss, ld_valid, st_done = 0 and req_ready = 1 immediately; a later dc_refill_done is ignored.
6. Back-to-back: three hit loads with req_valid held high -> accepts exactly every 3 cycles; ld_alid order matches request order.

Source files
------------

// File: rtl/mem_request_sequencer_pkg.sv
// mem_request_sequencer_pkg: shared FSM state, request record, cache action encoding
// and the saturating-increment helper used by the optional performance counters.
package mem_request_sequencer_pkg;

  localparam int MEM_ADDR_W    = 26;
  localparam int MEM_DATA_W    = 32;
  localparam int MEM_LSQ_IDX_W = 3;
  localparam int MEM_AL_IDX_W  = 5;
  localparam int PERF_W        = 32;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    MISS_WAIT,
    RESPOND
  } mem_seq_state_t;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_action_e;

  typedef struct packed {
    mem_action_e                write;
    logic [MEM_ADDR_W-1:0]      addr;
    logic [MEM_DATA_W-1:0]      data;
    logic [MEM_LSQ_IDX_W-1:0]   index;
    logic [MEM_AL_IDX_W-1:0]    alid;
    logic                       killed;
  } mem_req_t;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
    return (en && !(&v)) ? v + PERF_W'(1) : v;
  endfunction

endpackage

// File: rtl/mem_request_sequencer_perf_counters.sv
// mem_seq_perf_counters: saturating hit, miss and stall-cycle counters for the
// memory request sequencer (built only with MEM_SEQ_PERF_CNT_EN).
module mem_seq_perf_counters
  import mem_request_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hit_evt,
  input  logic              miss_evt,
  input  logic              stall_evt,
  output logic [PERF_W-1:0] perf_hit,
  output logic [PERF_W-1:0] perf_miss,
  output logic [PERF_W-1:0] perf_stall
);

  logic [PERF_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [PERF_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    hit_cnt_d      = sat_inc(hit_cnt_q, hit_evt);
    miss_cnt_d     = sat_inc(miss_cnt_q, miss_evt);
    stall_cycles_d = sat_inc(stall_cycles_q, stall_evt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q      <= '0;
      miss_cnt_q     <= '0;
      stall_cycles_q <= '0;
    end else begin
      hit_cnt_q      <= hit_cnt_d;
      miss_cnt_q     <= miss_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign perf_hit   = hit_cnt_q;
  assign perf_miss  = miss_cnt_q;
  assign perf_stall = stall_cycles_q;

endmodule

// File: rtl/mem_request_sequencer.sv
// mem_request_sequencer: holds one LSQ load/store while the data cache services it,
// replays after a refill, and returns tagged load data or store completion.
// Define MEM_SEQ_PERF_CNT_EN to add the perf_hit/perf_miss/perf_stall counter ports.
module mem_request_sequencer
  import mem_request_sequencer_pkg::*;
#(
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int DATA_W    = MEM_DATA_W,
  parameter int LSQ_IDX_W = MEM_LSQ_IDX_W,
  parameter int AL_IDX_W  = MEM_AL_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_data,
  input  logic [LSQ_IDX_W-1:0] req_index,
  input  logic [AL_IDX_W-1:0]  req_alid,
  input  logic                 flush,
  output logic                 dc_valid,
  output logic                 dc_write,
  output logic [ADDR_W-1:0]    dc_addr,
  output logic [DATA_W-1:0]    dc_wdata,
  input  logic                 dc_hit,
  input  logic [DATA_W-1:0]    dc_rdata,
  input  logic                 dc_refill_done,
  output logic                 dc_miss,
  output logic                 ld_valid,
  output logic [DATA_W-1:0]    ld_data,
  output logic [AL_IDX_W-1:0]  ld_alid,
  output logic                 st_done,
  output logic [LSQ_IDX_W-1:0] st_index
`ifdef MEM_SEQ_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]    perf_hit,
  output logic [PERF_W-1:0]    perf_miss,
  output logic [PERF_W-1:0]    perf_stall
`endif
);

  mem_seq_state_t state_q, state_d;
  mem_req_t held_q, held_d;
  logic req_ready_q, req_ready_d;
  logic ld_valid_q, ld_valid_d;
  logic st_done_q, st_done_d;
  logic [DATA_W-1:0] ld_data_q, ld_data_d;
  logic [AL_IDX_W-1:0] ld_alid_q, ld_alid_d;
  logic [LSQ_IDX_W-1:0] st_index_q, st_index_d;
  logic held_is_load, accept;

  assign held_is_load = held_q.write == MEM_READ;
  // A load seen together with a flush belongs to the squashed path and is refused.
  assign accept = req_valid && !(flush && !req_write);

  always_comb begin
    state_d        = state_q;
    held_d         = held_q;
    ld_valid_d     = 1'b0;
    st_done_d      = 1'b0;
    ld_data_d      = ld_data_q;
    ld_alid_d      = ld_alid_q;
    st_index_d     = st_index_q;
    held_d.killed  = held_q.killed | (state_q != IDLE && flush && held_is_load);
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d       = LOOKUP;
          held_d.write  = req_write ? MEM_WRITE : MEM_READ;
          held_d.addr   = req_addr;
          held_d.data   = req_data;
          held_d.index  = req_index;
          held_d.alid   = req_alid;
          held_d.killed = 1'b0;
        end
      end
      LOOKUP: begin
        state_d = dc_hit ? RESPOND : MISS_WAIT;
        if (dc_hit) begin
          ld_valid_d = held_is_load && !held_d.killed;
          st_done_d  = !held_is_load;
          ld_data_d  = held_is_load ? dc_rdata : ld_data_q;
          ld_alid_d  = held_is_load ? held_q.alid : ld_alid_q;
          st_index_d = held_is_load ? st_index_q : held_q.index;
        end
      end
      MISS_WAIT: state_d = dc_refill_done ? LOOKUP : MISS_WAIT;
      default:   state_d = IDLE;
    endcase
    req_ready_d = state_d == IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      held_q      <= '0;
      req_ready_q <= 1'b1;
      ld_valid_q  <= 1'b0;
      st_done_q   <= 1'b0;
      ld_data_q   <= '0;
      ld_alid_q   <= '0;
      st_index_q  <= '0;
    end else begin
      state_q     <= state_d;
      held_q      <= held_d;
      req_ready_q <= req_ready_d;
      ld_valid_q  <= ld_valid_d;
      st_done_q   <= st_done_d;
      ld_data_q   <= ld_data_d;
      ld_alid_q   <= ld_alid_d;
      st_index_q  <= st_index_d;
    end
  end

  assign req_ready = req_ready_q;
  assign dc_valid  = state_q == LOOKUP;
  assign dc_miss   = (state_q == LOOKUP && !dc_hit) || state_q == MISS_WAIT;
  assign dc_write  = held_q.write == MEM_WRITE;
  assign dc_addr   = held_q.addr;
  assign dc_wdata  = held_q.data;
  // A flush landing in the response cycle still squashes the load pulse.
  assign ld_valid  = ld_valid_q && !flush;
  assign ld_data   = ld_data_q;
  assign ld_alid   = ld_alid_q;
  assign st_done   = st_done_q;
  assign st_index  = st_index_q;

`ifdef MEM_SEQ_PERF_CNT_EN
  mem_seq_perf_counters u_perf (
    .clk        (clk),
    .rst_n      (rst_n),
    .hit_evt    (dc_valid && dc_hit),
    .miss_evt   (dc_valid && !dc_hit),
    .stall_evt  (dc_miss),
    .perf_hit   (perf_hit),
    .perf_miss  (perf_miss),
    .perf_stall (perf_stall)
  );
`endif

endmodule

// File: tb/tb_mem_request_sequencer.sv
// tb_mem_request_sequencer: directed scenarios plus a randomized run against a
// timeline/scoreboard model of the sequencer and a small cache model.
module tb_mem_request_sequencer;

  localparam int ADDR_W    = 26;
  localparam int DATA_W    = 32;
  localparam int LSQ_IDX_W = 3;
  localparam int AL_IDX_W  = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic req_valid, req_write, flush, dc_hit, dc_refill_done;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data, dc_rdata;
  logic [LSQ_IDX_W-1:0] req_index;
  logic [AL_IDX_W-1:0] req_alid;
  logic req_ready, dc_valid, dc_write, dc_miss, ld_valid, st_done;
  logic [ADDR_W-1:0] dc_addr;
  logic [DATA_W-1:0] dc_wdata, ld_data;
  logic [AL_IDX_W-1:0] ld_alid;
  logic [LSQ_IDX_W-1:0] st_index;
`ifdef MEM_SEQ_PERF_CNT_EN
  logic [31:0] perf_hit, perf_miss, perf_stall;
`endif

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mem_request_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data), .req_index(req_index), .req_alid(req_alid),
    .flush(flush),
    .dc_valid(dc_valid), .dc_write(dc_write), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_hit(dc_hit), .dc_rdata(dc_rdata), .dc_refill_done(dc_refill_done), .dc_miss(dc_miss),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_alid(ld_alid),
    .st_done(st_done), .st_index(st_index)
`ifdef MEM_SEQ_PERF_CNT_EN
    , .perf_hit(perf_hit), .perf_miss(perf_miss), .perf_stall(perf_stall)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    req_valid = 0; req_write = 0; req_addr = '0; req_data = '0; req_index = '0; req_alid = '0;
    flush = 0; dc_hit = 0; dc_rdata = '0; dc_refill_done = 0;
  endtask

  task automatic test_reset();
    #1 rst_n = 0;
    #2;
    checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready); else passes++;
    checks++; if (dc_valid !== 1'b0) $display("FAIL reset_dc_valid: got %b want 0", dc_valid); else passes++;
    checks++; if (dc_miss !== 1'b0) $display("FAIL reset_dc_miss: got %b want 0", dc_miss); else passes++;
    checks++; if ({ld_valid, st_done} !== 2'b00) $display("FAIL reset_pulses: got %b want 00", {ld_valid, st_done}); else passes++;
    checks++; if ({dc_write, dc_addr, dc_wdata, ld_data, ld_alid, st_index} !== '0)
      $display("FAIL reset_data: got nonzero data/index outputs want 0"); else passes++;
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_load_hit();
    clr(); req_valid = 1; req_addr = 26'h40; req_alid = 5; #1;
    checks++; if (req_ready !== 1'b1) $display("FAIL lh_accept_ready: got %b want 1", req_ready); else passes++;
    tick(); clr(); dc_hit = 1; dc_rdata = 32'hDEADBEEF; #1;
    checks++; if ({dc_valid, dc_write, dc_miss} !== 3'b100) $display("FAIL lh_lookup: got %b want 100", {dc_valid, dc_write, dc_miss}); else passes++;
    checks++; if (dc_addr !== 26'h40) $display("FAIL lh_addr: got %h want 40", dc_addr); else passes++;
    checks++; if (req_ready !== 1'b0) $display("FAIL lh_ready_n1: got %b want 0", req_ready); else passes++;
    tick(); clr(); #1;
    checks++; if (ld_valid !== 1'b1) $display("FAIL lh_ld_valid: got %b want 1", ld_valid); else passes++;
    checks++; if (ld_data !== 32'hDEADBEEF) $display("FAIL lh_ld_data: got %h want deadbeef", ld_data); else passes++;
    checks++; if (ld_alid !== 5'd5) $display("FAIL lh_ld_alid: got %0d want 5", ld_alid); else passes++;
    checks++; if ({req_ready, st_done} !== 2'b00) $display("FAIL lh_ready_n2: got %b want 00", {req_ready, st_done}); else passes++;
    tick(); #1;
    checks++; if ({ld_valid, req_ready} !== 2'b01) $display("FAIL lh_after: got %b want 01", {ld_valid, req_ready}); else passes++;
  endtask

  task automatic test_store_miss();
    int nv = 0;
    for (int k = 0; k < 10; k++) begin
      clr();
      req_valid = k == 0; req_write = 1; req_addr = 26'h80; req_data = 32'h1234; req_index = 3;
      dc_hit = k == 7; dc_refill_done = k == 6;
      #1;
      nv += int'(dc_valid);
      checks++; if (dc_miss !== (k >= 1 && k <= 6)) $display("FAIL sm_dc_miss k=%0d: got %b want %b", k, dc_miss, k >= 1 && k <= 6); else passes++;
      checks++; if (st_done !== (k == 8)) $display("FAIL sm_st_done k=%0d: got %b want %b", k, st_done, k == 8); else passes++;
      if (k == 8) begin
        checks++; if (st_index !== 3'd3) $display("FAIL sm_st_index: got %0d want 3", st_index); else passes++;
      end
      if (k == 1 || k == 7) begin
        checks++; if ({dc_write, dc_addr, dc_wdata} !== {1'b1, 26'h80, 32'h1234})
          $display("FAIL sm_access k=%0d: got %b/%h/%h want 1/80/1234", k, dc_write, dc_addr, dc_wdata); else passes++;
      end
      tick();
    end
    checks++; if (nv != 2) $display("FAIL sm_strobes: got %0d want 2", nv); else passes++;
  endtask

  task automatic test_flush_load_miss();
    for (int k = 0; k < 9; k++) begin
      clr();
      req_valid = k == 0; req_addr = 26'h100; req_alid = 7;
      flush = k == 3; dc_refill_done = k == 5; dc_hit = k == 6; dc_rdata = 32'h55;
      #1;
      checks++; if (ld_valid !== 1'b0) $display("FAIL flm_ld_valid k=%0d: got %b want 0", k, ld_valid); else passes++;
      if (k == 6) begin
        checks++; if (dc_valid !== 1'b1) $display("FAIL flm_replay: got %b want 1", dc_valid); else passes++;
      end
      if (k == 8) begin
        checks++; if (req_ready !== 1'b1) $display("FAIL flm_ready: got %b want 1", req_ready); else passes++;
      end
      tick();
    end
  endtask

  task automatic test_flush_store();
    for (int k = 0; k < 4; k++) begin
      clr();
      req_valid = k == 0; req_write = 1; req_addr = 26'h20; req_data = 32'h77; req_index = 2;
      flush = k == 1; dc_hit = k == 1;
      #1;
      checks++; if (st_done !== (k == 2)) $display("FAIL fs_st_done k=%0d: got %b want %b", k, st_done, k == 2); else passes++;
      if (k == 2) begin
        checks++; if (st_index !== 3'd2) $display("FAIL fs_st_index: got %0d want 2", st_index); else passes++;
      end
      tick();
    end
    checks++; if (req_ready !== 1'b1) $display("FAIL fs_ready: got %b want 1", req_ready); else passes++;
  endtask

  task automatic test_async_reset();
    clr(); req_valid = 1; req_addr = 26'h200; req_alid = 9; #1;
    tick(); clr(); #1;
    tick(); #1;
    checks++; if (dc_miss !== 1'b1) $display("FAIL ar_pre_miss: got %b want 1", dc_miss); else passes++;
    rst_n = 0; #1;
    checks++; if ({dc_miss, ld_valid, st_done, dc_valid} !== 4'b0000)
      $display("FAIL ar_outputs: got %b want 0000", {dc_miss, ld_valid, st_done, dc_valid}); else passes++;
    checks++; if (req_ready !== 1'b1) $display("FAIL ar_ready: got %b want 1", req_ready); else passes++;
    rst_n = 1;
    tick(); dc_refill_done = 1; #1;
    tick(); dc_refill_done = 0; #1;
    checks++; if ({dc_valid, dc_miss, req_ready} !== 3'b001)
      $display("FAIL ar_refill_ignored: got %b want 001", {dc_valid, dc_miss, req_ready}); else passes++;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 9; k++) begin
      clr();
      req_valid = 1; req_addr = ADDR_W'(k / 3 + 1); req_alid = AL_IDX_W'(11 + k / 3);
      dc_hit = 1; dc_rdata = 32'hC0DE0000 + 32'(k / 3);
      #1;
      checks++; if (req_ready !== (k % 3 == 0)) $display("FAIL b2b_ready k=%0d: got %b want %b", k, req_ready, k % 3 == 0); else passes++;
      checks++; if (ld_valid !== (k % 3 == 2)) $display("FAIL b2b_ld_valid k=%0d: got %b want %b", k, ld_valid, k % 3 == 2); else passes++;
      if (k % 3 == 2) begin
        checks++; if (ld_alid !== AL_IDX_W'(11 + k / 3)) $display("FAIL b2b_alid k=%0d: got %0d want %0d", k, ld_alid, 11 + k / 3); else passes++;
        checks++; if (ld_data !== 32'hC0DE0000 + 32'(k / 3)) $display("FAIL b2b_data k=%0d: got %h want %h", k, ld_data, 32'hC0DE0000 + 32'(k / 3)); else passes++;
      end
      tick();
    end
    clr();
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] arch [16];
    logic [DATA_W-1:0] cmem [16];
    bit res [16];
    bit have, busy, waiting, kill, acc_now, exp_ld, exp_st;
    logic nw, w;
    logic [3:0] na, a;
    logic [DATA_W-1:0] nd, d, exp_data;
    logic [LSQ_IDX_W-1:0] ni, idx;
    logic [AL_IDX_W-1:0] nal, alid;
    int acc = -1, resp = -1, refill = -1;
    have = 0; busy = 0; waiting = 0; kill = 0; w = 0; a = 0; d = 0; idx = 0; alid = 0; exp_data = 0;
    nw = 0; na = 0; nd = 0; ni = 0; nal = 0;
    for (int i = 0; i < 16; i++) begin
      arch[i] = 32'hA5000000 ^ (32'(i) * 32'h01010101);
      cmem[i] = arch[i];
      res[i] = 0;
    end
    for (int c = 0; c < 600; c++) begin
      if (!have) begin
        have = $urandom % 2 == 0;
        nw = 1'($urandom % 2); na = 4'($urandom); nd = $urandom; ni = LSQ_IDX_W'($urandom); nal = AL_IDX_W'($urandom);
      end
      req_valid = have; req_write = nw; req_addr = ADDR_W'(na); req_data = nd; req_index = ni; req_alid = nal;
      flush = $urandom % 6 == 0;
      acc_now = busy && c == acc;
      dc_hit = acc_now ? res[a] : 1'($urandom % 2);
      dc_rdata = (acc_now && res[a] && !w) ? cmem[a] : $urandom;
      dc_refill_done = (c == refill) || (!waiting && $urandom % 10 == 0);
      #1;
      kill = kill | (busy && !w && flush);
      exp_ld = busy && c == resp && !w && !kill;
      exp_st = busy && c == resp && w;
      checks++; if (req_ready !== !busy) $display("FAIL rnd_ready c=%0d: got %b want %b", c, req_ready, !busy); else passes++;
      checks++; if (dc_valid !== acc_now) $display("FAIL rnd_dc_valid c=%0d: got %b want %b", c, dc_valid, acc_now); else passes++;
      checks++; if (dc_miss !== ((acc_now && !res[a]) || waiting)) $display("FAIL rnd_dc_miss c=%0d: got %b want %b", c, dc_miss, (acc_now && !res[a]) || waiting); else passes++;
      if (acc_now) begin
        checks++; if (dc_addr !== ADDR_W'(a) || dc_write !== w || (w && dc_wdata !== d))
          $display("FAIL rnd_access c=%0d: got %h/%b/%h want %h/%b/%h", c, dc_addr, dc_write, dc_wdata, a, w, d); else passes++;
      end
      checks++; if (ld_valid !== exp_ld) $display("FAIL rnd_ld_valid c=%0d: got %b want %b", c, ld_valid, exp_ld); else passes++;
      checks++; if (st_done !== exp_st) $display("FAIL rnd_st_done c=%0d: got %b want %b", c, st_done, exp_st); else passes++;
      if (exp_ld) begin
        checks++; if (ld_data !== exp_data || ld_alid !== alid)
          $display("FAIL rnd_ld_resp c=%0d: got %h/%0d want %h/%0d", c, ld_data, ld_alid, exp_data, alid); else passes++;
      end
      if (exp_st) begin
        checks++; if (st_index !== idx) $display("FAIL rnd_st_index c=%0d: got %0d want %0d", c, st_index, idx); else passes++;
      end
      if (busy) begin
        if (acc_now) begin
          if (res[a]) begin
            resp = c + 1;
            if (w) cmem[a] = d;
          end else begin
            waiting = 1;
            refill = c + 1 + int'($urandom % 5);
          end
        end
        if (c == refill) begin
          waiting = 0; res[a] = 1; acc = c + 1; refill = -1;
        end
        if (c == resp) busy = 0;
      end else if (have && !(flush && !nw)) begin
        busy = 1; have = 0; kill = 0;
        w = nw; a = na; d = nd; idx = ni; alid = nal;
        acc = c + 1; resp = -1;
        exp_data = arch[na];
        if (nw) arch[na] = nd;
        if ($urandom % 3 == 0) res[na] = 0;
      end
      tick();
    end
    clr();
  endtask

  initial begin
    clr();
    test_reset();
    test_load_hit();
    test_store_miss();
    test_flush_load_miss();
    test_flush_store();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
